// File: rtl/diff_deser_framer.sv
// diff_deser_framer: multi-lane serial-to-parallel deserialiser
// that hunts for a lane-0 sync word, verifies it, then emits aligned words.
module diff_deser_framer #(
   parameter int                LANES       = 2,
   parameter int                WIDTH       = 8,
   parameter logic [WIDTH-1:0]  SYNC_WORD   = 'hA5,
   parameter int                FRAME_WORDS = 4,
   parameter int                LOCK_COUNT  = 2,
   parameter int                LOSE_COUNT  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [LANES-1:0]         data_in,
   input  logic                     resync,
   input  logic                     sel,
   output logic [LANES*WIDTH-1:0]   q,
   output logic                     q_valid,
   output logic                     locked,
   output logic                     frame_start,
   output logic                     data_out
);

   localparam int BW = $clog2(WIDTH);
   localparam int FW = $clog2(FRAME_WORDS);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t                  state;
   logic [WIDTH-1:0]        sr    [LANES];
   logic [WIDTH-1:0]        sr_nx [LANES];
   logic [LANES*WIDTH-1:0]  word_nx;
   logic [BW-1:0]           bit_cnt;
   logic [FW-1:0]           fidx;
   logic [FW-1:0]           fidx_inc;
   logic [3:0]              hits;
   logic [3:0]              misses;
   logic                    loop_q;
   logic                    done;
   logic                    slot;
   logic                    sync_ok;

   // Next shift-register contents: the word as it stands after this edge.
   always_comb begin
      word_nx = '0;
      for (int n = 0; n < LANES; n++) begin
         sr_nx[n] = {sr[n][WIDTH-2:0], data_in[n]};
         word_nx[n*WIDTH +: WIDTH] = sr_nx[n];
      end
   end

   assign done     = (bit_cnt == BW'(WIDTH-1));
   assign slot     = (fidx == '0);
   assign sync_ok  = (sr_nx[0] == SYNC_WORD);
   assign fidx_inc = (fidx == FW'(FRAME_WORDS-1)) ? '0 : fidx + 1'b1;

   // Per-lane shifters run in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < LANES; n++) sr[n] <= '0;
      end else begin
         for (int n = 0; n < LANES; n++) sr[n] <= sr_nx[n];
      end
   end

   // Lane-0 loopback tap for the monitor output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) loop_q <= 1'b0;
      else        loop_q <= data_in[0];
   end

   assign data_out = sel ? locked : loop_q;

   // Framing FSM with registered word, strobe and lock outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         bit_cnt     <= '0;
         fidx        <= '0;
         hits        <= '0;
         misses      <= '0;
         q           <= '0;
         q_valid     <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
      end else begin
         q_valid     <= 1'b0;
         frame_start <= 1'b0;
         if (resync) begin
            state   <= HUNT;
            bit_cnt <= '0;
            fidx    <= '0;
            hits    <= '0;
            misses  <= '0;
            locked  <= 1'b0;
         end else begin
            if (state != HUNT) begin
               bit_cnt <= done ? '0 : bit_cnt + 1'b1;
               if (done) fidx <= fidx_inc;
            end
            case (state)
               HUNT: begin
                  bit_cnt <= '0;
                  fidx    <= '0;
                  locked  <= 1'b0;
                  if (sync_ok) begin
                     state <= VERIFY;
                     fidx  <= FW'(1);
                     hits  <= '0;
                  end
               end
               VERIFY: begin
                  if (done && slot) begin
                     if (sync_ok) begin
                        hits <= hits + 4'd1;
                        if (hits + 4'd1 == 4'(LOCK_COUNT)) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                           misses <= '0;
                        end
                     end else begin
                        state   <= HUNT;
                        bit_cnt <= '0;
                        fidx    <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (done && !slot) begin
                     q           <= word_nx;
                     q_valid     <= 1'b1;
                     frame_start <= (fidx == FW'(1));
                  end else if (done) begin
                     if (sync_ok) begin
                        misses <= '0;
                     end else if (misses + 4'd1 == 4'(LOSE_COUNT)) begin
                        state   <= HUNT;
                        locked  <= 1'b0;
                        bit_cnt <= '0;
                        fidx    <= '0;
                        misses  <= '0;
                     end else begin
                        misses <= misses + 4'd1;
                     end
                  end
               end
               default: begin
                  state   <= HUNT;
                  bit_cnt <= '0;
                  fidx    <= '0;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_diff_deser_framer.sv
// tb_diff_deser_framer: table vectors, directed corner sequences and
// random framed streams checked against a stream-level reference model.
module tb_diff_deser_framer;

   localparam int          W     = 8;
   localparam int          FWN   = 4;
   localparam int          LOCKN = 2;
   localparam int          LOSEN = 2;
   localparam logic [7:0]  SYNC  = 8'hA5;

   logic        clk;
   logic        rst_n;
   logic [1:0]  data_in;
   logic        resync;
   logic        sel;
   logic [15:0] q;
   logic        q_valid;
   logic        locked;
   logic        frame_start;
   logic        data_out;

   diff_deser_framer #(
      .LANES(2), .WIDTH(8), .SYNC_WORD(8'hA5),
      .FRAME_WORDS(4), .LOCK_COUNT(2), .LOSE_COUNT(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .resync(resync), .sel(sel), .q(q), .q_valid(q_valid),
      .locked(locked), .frame_start(frame_start), .data_out(data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: last W received bit pairs plus mode and age since sync.
   logic [1:0]  stream[$];
   int          mode;
   int          age;
   int          hits;
   int          misses;
   logic [15:0] mq;
   logic        mqv, mfs, mlk, mdo;

   typedef struct packed {
      logic [7:0] l0;
      logic [7:0] l1;
      logic       lk;
      logic       qv;
      logic       fs;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      stream.delete();
      for (int i = 0; i < W; i++) stream.push_back(2'b00);
      mode = 0; age = 0; hits = 0; misses = 0;
      mq = '0; mqv = 0; mfs = 0; mlk = 0; mdo = 0;
   endtask

   function automatic logic [7:0] mword(input int n);
      logic [7:0] w;
      w = '0;
      for (int i = 0; i < W; i++) w[W-1-i] = stream[i][n];
      return w;
   endfunction

   task automatic model_edge(input logic [1:0] d, input logic rs,
                             input logic s);
      logic [7:0] w0, w1;
      int k;
      stream.push_back(d);
      void'(stream.pop_front());
      w0 = mword(0);
      w1 = mword(1);
      mqv = 0;
      mfs = 0;
      if (rs) begin
         mode = 0;
      end else if (mode == 0) begin
         if (w0 == SYNC) begin
            mode = 1; age = 0; hits = 0;
         end
      end else begin
         age++;
         if (age % W == 0) begin
            k = (age / W) % FWN;
            if (mode == 1) begin
               if (k == 0) begin
                  if (w0 == SYNC) begin
                     hits++;
                     if (hits == LOCKN) begin
                        mode = 2; misses = 0;
                     end
                  end else begin
                     mode = 0;
                  end
               end
            end else if (k != 0) begin
               mq = {w1, w0}; mqv = 1; mfs = (k == 1);
            end else if (w0 == SYNC) begin
               misses = 0;
            end else begin
               misses++;
               if (misses == LOSEN) mode = 0;
            end
         end
      end
      mlk = (mode == 2);
      mdo = s ? mlk : d[0];
   endtask

   task automatic check_all();
      chk("locked", 32'(locked), 32'(mlk));
      chk("q_valid", 32'(q_valid), 32'(mqv));
      chk("frame_start", 32'(frame_start), 32'(mfs));
      chk("q", 32'(q), 32'(mq));
      chk("data_out", 32'(data_out), 32'(mdo));
   endtask

   // Caller sits at a falling edge; returns at the next falling edge.
   task automatic step(input logic [1:0] d, input logic rs, input logic s);
      data_in = d;
      resync  = rs;
      sel     = s;
      @(posedge clk);
      #1;
      model_edge(d, rs, s);
      check_all();
      @(negedge clk);
   endtask

   task automatic send_word(input logic [7:0] l0, input logic [7:0] l1,
                            input int rs_at, input logic s);
      for (int b = W - 1; b >= 0; b--)
         step({l1[b], l0[b]}, (b == rs_at), s);
   endtask

   task automatic add(input logic [7:0] l0, input logic [7:0] l1,
                      input logic lk, input logic qv, input logic fs);
      tbl.push_back('{l0: l0, l1: l1, lk: lk, qv: qv, fs: fs});
   endtask

   task automatic pay(input logic lk, input logic qv);
      add(8'h11, 8'h44, lk, qv, qv);
      add(8'h22, 8'h55, lk, qv, 1'b0);
      add(8'h33, 8'h66, lk, qv, 1'b0);
   endtask

   initial begin
      int off;
      logic [7:0] a, b;

      add(8'hA5, 8'h00, 0, 0, 0); pay(0, 0);
      add(8'hA5, 8'h00, 0, 0, 0); pay(0, 0);
      add(8'hA5, 8'h00, 1, 0, 0); pay(1, 1);
      add(8'hA5, 8'h00, 1, 0, 0);
      add(8'h11, 8'h44, 1, 1, 1);
      add(8'hA5, 8'h55, 1, 1, 0);
      add(8'h33, 8'h66, 1, 1, 0);
      add(8'hA4, 8'h00, 1, 0, 0); pay(1, 1);
      add(8'hA5, 8'h00, 1, 0, 0); pay(1, 1);
      add(8'hA4, 8'h00, 1, 0, 0); pay(1, 1);
      add(8'hA4, 8'h00, 0, 0, 0); pay(0, 0);
      add(8'hA5, 8'h00, 0, 0, 0); pay(0, 0);
      add(8'h5A, 8'h00, 0, 0, 0); pay(0, 0);
      add(8'hA5, 8'h00, 0, 0, 0); pay(0, 0);
      add(8'hA5, 8'h00, 0, 0, 0); pay(0, 0);
      add(8'hA5, 8'h00, 1, 0, 0);
      add(8'h11, 8'h44, 1, 1, 1);

      rst_n = 1'b1; data_in = '0; resync = 0; sel = 0;
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_q_valid", 32'(q_valid), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_frame_start", 32'(frame_start), 32'h0);
      chk("rst_data_out", 32'(data_out), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      off = $urandom_range(0, 7);
      for (int i = 0; i < off; i++) step(2'b00, 0, 0);
      foreach (tbl[i]) begin
         send_word(tbl[i].l0, tbl[i].l1, -1, 0);
         chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
         chk($sformatf("tbl%0d_q_valid", i), 32'(q_valid), 32'(tbl[i].qv));
         chk($sformatf("tbl%0d_frame_start", i), 32'(frame_start),
             32'(tbl[i].fs));
         if (tbl[i].qv)
            chk($sformatf("tbl%0d_q", i), 32'(q), 32'({tbl[i].l1, tbl[i].l0}));
      end

      send_word(8'h22, 8'h55, 4, 0);
      chk("resync_mid_locked", 32'(locked), 32'h0);
      chk("resync_mid_q_valid", 32'(q_valid), 32'h0);
      send_word(8'h33, 8'h66, -1, 0);
      for (int f = 0; f < 2; f++) begin
         send_word(8'hA5, 8'h00, -1, 0);
         send_word(8'h11, 8'h44, -1, 0);
         send_word(8'h22, 8'h55, -1, 0);
         send_word(8'h33, 8'h66, -1, 0);
      end
      send_word(8'hA5, 8'h00, -1, 1);
      chk("relock_locked", 32'(locked), 32'h1);
      chk("relock_data_out", 32'(data_out), 32'h1);
      send_word(8'h11, 8'h44, 0, 1);
      chk("resync_edge_q_valid", 32'(q_valid), 32'h0);
      chk("resync_edge_frame_start", 32'(frame_start), 32'h0);
      chk("resync_edge_data_out", 32'(data_out), 32'h0);

      for (int f = 0; f < 3; f++) begin
         send_word(8'hA5, 8'h00, -1, 0);
         send_word(8'h11, 8'h44, -1, 0);
         send_word(8'h22, 8'h55, -1, 0);
         send_word(8'h33, 8'h66, -1, 0);
      end
      send_word(8'hA5, 8'h00, -1, 0);
      send_word(8'h11, 8'h44, -1, 0);
      chk("pre_rst_locked", 32'(locked), 32'h1);
      for (int i = 0; i < 3; i++) step(2'b11, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_locked", 32'(locked), 32'h0);
      chk("midrst_q_valid", 32'(q_valid), 32'h0);
      chk("midrst_q", 32'(q), 32'h0);
      chk("midrst_data_out", 32'(data_out), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < 4; r++) begin
         off = $urandom_range(0, 15);
         for (int i = 0; i < off; i++)
            step(2'($urandom), 0, 1'($urandom));
         for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < FWN; k++) begin
               logic s;
               b = 8'($urandom);
               if (k == 0)
                  a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : SYNC;
               else
                  a = ($urandom_range(0, 9) == 0) ? SYNC : 8'($urandom);
               s = 1'($urandom);
               for (int bi = W - 1; bi >= 0; bi--)
                  step({b[bi], a[bi]}, ($urandom_range(0, 299) == 0), s);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
